pe_acc: RTL and testbench

PE_ACC -- requirements
Module: pe_acc

---
 rtl/pe_pkg.sv | 7 +
 rtl/pe_sat.sv | 15 +
 rtl/pe_acc.sv | 120 ++++++++++++
 tb/tb_pe_acc.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: mode encodings and FSM state type shared by the PE accumulator
package pe_pkg;
    localparam logic [1:0] MODE_MAC = 2'd0;
    localparam logic [1:0] MODE_MAX = 2'd1;
    localparam logic [1:0] MODE_SUM = 2'd2;
    typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;
endpackage

// File: rtl/pe_sat.sv
// pe_sat: signed clamp of a wide value into OUT_WIDTH bits with a saturation flag
module pe_sat #(
    parameter int IN_WIDTH  = 24,
    parameter int OUT_WIDTH = 16
) (
    input  logic [IN_WIDTH-1:0]  value,
    output logic [OUT_WIDTH-1:0] result,
    output logic                 sat
);
    logic [IN_WIDTH-OUT_WIDTH:0] upper;
    assign upper  = value[IN_WIDTH-1:OUT_WIDTH-1];
    // in range exactly when the dropped bits are all copies of the new sign bit
    assign sat    = !((&upper) || !(|upper));
    assign result = sat ? {value[IN_WIDTH-1], {(OUT_WIDTH-1){~value[IN_WIDTH-1]}}} : value[OUT_WIDTH-1:0];
endmodule

// File: rtl/pe_acc.sv
// pe_acc: two-stage MAC/MAX/SUM accumulator with saturated, handshaked result
module pe_acc import pe_pkg::*; #(
    parameter int IFM_WIDTH    = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int PSUM_WIDTH   = 24,
    parameter int OUT_WIDTH    = 16,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [1:0]            mode,
    input  logic [CNT_WIDTH-1:0]  len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IFM_WIDTH-1:0]  ifm,
    input  logic [WEIGHT_WIDTH-1:0] wgt,
    input  logic [PSUM_WIDTH-1:0] psum_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_sat,
    output logic                  busy
);
    if (PSUM_WIDTH < IFM_WIDTH + WEIGHT_WIDTH + CNT_WIDTH) begin : g_width_check
        $error("pe_acc: PSUM_WIDTH too small for worst-case accumulation");
    end

    state_t state, state_nx;
    logic live, accept, last_beat;
    logic [1:0] mode_q, eff_mode;
    logic [CNT_WIDTH-1:0] len_q, count;
    logic s1_valid, s1_first, s1_last, s2_last;
    logic signed [IFM_WIDTH+WEIGHT_WIDTH-1:0] prod;
    logic signed [PSUM_WIDTH-1:0] term_nx, s1_term, acc, base, acc_nx;
    logic [OUT_WIDTH-1:0] sat_data;
    logic sat_flag;

    // live keeps in_ready low while in reset and for the first edge after it
    assign in_ready  = live && (state == IDLE || state == ACC);
    assign busy      = state != IDLE;
    assign accept    = in_valid && in_ready;
    assign eff_mode  = state == IDLE ? mode : mode_q;
    assign last_beat = state == IDLE ? len < CNT_WIDTH'(2) : count + CNT_WIDTH'(1) == len_q;
    assign prod      = $signed(ifm) * $signed(wgt);
    assign term_nx   = (eff_mode == MODE_MAX || eff_mode == MODE_SUM)
                     ? {{(PSUM_WIDTH-IFM_WIDTH){ifm[IFM_WIDTH-1]}}, ifm}
                     : {{(PSUM_WIDTH-IFM_WIDTH-WEIGHT_WIDTH){prod[IFM_WIDTH+WEIGHT_WIDTH-1]}}, prod};
    assign base      = s1_first ? $signed(psum_in) : acc;
    assign acc_nx    = mode_q == MODE_MAX ? (s1_term > base ? s1_term : base) : base + s1_term;

    pe_sat #(.IN_WIDTH(PSUM_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_sat (
        .value  (acc),
        .result (sat_data),
        .sat    (sat_flag)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = last_beat ? DRAIN : ACC;
            ACC:     if (accept && last_beat) state_nx = DRAIN;
            DRAIN:   if (s1_valid && s1_last) state_nx = OUT;
            OUT:     if (out_valid && out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (clear) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            live      <= 1'b0;
            mode_q    <= MODE_MAC;
            len_q     <= '0;
            count     <= '0;
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_term   <= '0;
            s2_last   <= 1'b0;
            acc       <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
            if (clear) begin
                count     <= '0;
                s1_valid  <= 1'b0;
                s2_last   <= 1'b0;
                acc       <= '0;
                out_sat   <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                s1_valid <= accept;
                s2_last  <= s1_valid && s1_last;
                if (accept) begin
                    s1_term  <= term_nx;
                    s1_first <= state == IDLE;
                    s1_last  <= last_beat;
                    count    <= state == IDLE ? CNT_WIDTH'(1) : count + CNT_WIDTH'(1);
                    if (state == IDLE) begin
                        mode_q <= mode;
                        len_q  <= len == '0 ? CNT_WIDTH'(1) : len;
                    end
                end
                if (s1_valid) acc <= acc_nx;
                if (s2_last) begin
                    out_data  <= sat_data;
                    out_sat   <= sat_flag;
                    out_valid <= 1'b1;
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pe_acc.sv
// tb_pe_acc: table vectors, randomized jobs against an arithmetic model, and abort sequences
module tb_pe_acc;
    import pe_pkg::*;
    localparam int IW = 8, WW = 8, PW = 24, OW = 16, CW = 8;

    logic clk = 0, rst_n = 0, clear = 0, in_valid = 0, out_ready = 0;
    logic [1:0] mode = 0;
    logic [CW-1:0] len = 0;
    logic [IW-1:0] ifm = 0;
    logic [WW-1:0] wgt = 0;
    logic [PW-1:0] psum_in = 0;
    logic in_ready, out_valid, out_sat, busy;
    logic [OW-1:0] out_data;
    int checks = 0, errors = 0;
    int jifm[16], jwgt[16];

    typedef struct packed {
        logic [1:0] mode;
        int len, psum, i0, i1, i2, i3, w0, w1, w2, w3, exp_data;
        bit exp_sat;
    } vec_t;

    pe_acc #(.IFM_WIDTH(IW), .WEIGHT_WIDTH(WW), .PSUM_WIDTH(PW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .ifm(ifm), .wgt(wgt), .psum_in(psum_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // reference: fold the terms with plain integer arithmetic, then clamp
    function automatic void model(input logic [1:0] m, input int l, input int p, output int d, output bit s);
        longint a = p;
        int n = l < 2 ? 1 : l;
        for (int i = 0; i < n; i++) begin
            longint t = (m == MODE_MAX || m == MODE_SUM) ? longint'(jifm[i]) : longint'(jifm[i]) * longint'(jwgt[i]);
            a = (m == MODE_MAX) ? (t > a ? t : a) : a + t;
        end
        s = a > 32767 || a < -32768;
        d = a > 32767 ? 32767 : a < -32768 ? -32768 : int'(a);
    endfunction

    task automatic run_job(input string tag, input logic [1:0] m, input int l, input int p,
                           input int ed, input bit es, input int hold, input bit gaps);
        int n = l < 2 ? 1 : l;
        int cyc = 0;
        bit ok = 1;
        while (!in_ready && cyc < 20) begin @(posedge clk); @(negedge clk); cyc++; end
        chk({tag, " ready"}, in_ready, 1);
        mode = m; len = CW'(l); psum_in = PW'(p);
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 1) == 1) begin
                in_valid = 0;
                @(posedge clk); @(negedge clk);
            end
            in_valid = 1; ifm = jifm[i][IW-1:0]; wgt = jwgt[i][WW-1:0];
            @(posedge clk); @(negedge clk);
            if (i == 0) begin mode = 2'($urandom); len = CW'($urandom); end
        end
        in_valid = 0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin @(posedge clk); @(negedge clk); cyc++; end
        chk({tag, " latency"}, cyc, 2);
        chk({tag, " data"}, $signed(out_data), ed);
        chk({tag, " sat"}, out_sat, es);
        chk({tag, " ready low"}, in_ready, 0);
        if (hold > 0) begin
            logic [OW-1:0] d0 = out_data;
            logic s0 = out_sat;
            in_valid = 1; ifm = 8'h55; wgt = 8'h11;
            repeat (hold) begin
                @(posedge clk); @(negedge clk);
                ok &= out_valid && out_data == d0 && out_sat == s0 && !in_ready;
            end
            chk({tag, " hold"}, ok, 1);
            in_valid = 0;
        end
        out_ready = 1;
        @(posedge clk); @(negedge clk);
        out_ready = 0;
        chk({tag, " done"}, {out_valid, busy, in_ready}, 3'b001);
    endtask

    task automatic abort_job(input string tag, input bit use_rst);
        bit seen = 0;
        int d;
        bit s;
        mode = MODE_MAC; len = 4; psum_in = 0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; ifm = 8'd9; wgt = 8'd7;
            @(posedge clk); @(negedge clk);
        end
        in_valid = 0;
        if (use_rst) begin
            rst_n = 0;
            #1;
            chk({tag, " async idle"}, {busy, in_ready, out_valid}, 3'b000);
            @(negedge clk);
            rst_n = 1;
            @(posedge clk); @(negedge clk);
        end else begin
            clear = 1;
            @(posedge clk); @(negedge clk);
            clear = 0;
        end
        chk({tag, " busy"}, busy, 0);
        repeat (6) begin @(posedge clk); @(negedge clk); seen |= out_valid; end
        chk({tag, " no result"}, seen, 0);
        jifm[0] = -6; jwgt[0] = 7; jifm[1] = 11; jwgt[1] = 3;
        model(MODE_MAC, 2, 5, d, s);
        run_job({tag, " fresh"}, MODE_MAC, 2, 5, d, s, 0, 0);
    endtask

    initial begin
        vec_t vecs[7];
        int d;
        bit s;
        vecs[0] = '{MODE_MAC, 3, 10, 2, 4, 5, 0, 3, -1, 5, 0, 37, 1'b0};
        vecs[1] = '{MODE_MAX, 4, -128, 3, -7, 12, 5, 1, 1, 1, 1, 12, 1'b0};
        vecs[2] = '{MODE_MAC, 4, 0, 127, 127, 127, 127, 127, 127, 127, 127, 32767, 1'b1};
        vecs[3] = '{MODE_SUM, 0, 4, -9, 0, 0, 0, 3, 0, 0, 0, -5, 1'b0};
        vecs[4] = '{MODE_SUM, 1, 4, -9, 0, 0, 0, 3, 0, 0, 0, -5, 1'b0};
        vecs[5] = '{MODE_MAC, 2, -1000, -128, -128, 0, 0, 127, 127, 0, 0, -32768, 1'b1};
        vecs[6] = '{2'd3, 2, 1, 3, -2, 0, 0, 4, 5, 0, 0, 3, 1'b0};

        @(negedge clk); @(negedge clk);
        chk("reset outputs", {in_ready, busy, out_valid, out_sat}, 4'b0000);
        chk("reset data", out_data, 0);
        rst_n = 1;
        #1;
        chk("ready before edge", in_ready, 0);
        @(posedge clk); @(negedge clk);
        chk("ready after edge", in_ready, 1);

        for (int i = 0; i < 7; i++) begin
            jifm[0] = vecs[i].i0; jifm[1] = vecs[i].i1; jifm[2] = vecs[i].i2; jifm[3] = vecs[i].i3;
            jwgt[0] = vecs[i].w0; jwgt[1] = vecs[i].w1; jwgt[2] = vecs[i].w2; jwgt[3] = vecs[i].w3;
            run_job($sformatf("vec%0d", i), vecs[i].mode, vecs[i].len, vecs[i].psum,
                    vecs[i].exp_data, vecs[i].exp_sat, i == 0 ? 5 : 0, i == 1);
        end

        for (int j = 0; j < 25; j++) begin
            logic [1:0] m = 2'($urandom_range(0, 3));
            int l = int'($urandom_range(0, 6));
            int p = int'($urandom_range(0, 80000)) - 40000;
            for (int i = 0; i < 6; i++) begin
                jifm[i] = int'($urandom_range(0, 255)) - 128;
                jwgt[i] = int'($urandom_range(0, 255)) - 128;
            end
            model(m, l, p, d, s);
            run_job($sformatf("rnd%0d", j), m, l, p, d, s, int'($urandom_range(0, 3)), 1);
        end

        abort_job("clear", 0);
        abort_job("rst", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
